// File: rtl/uart_baud_pkg.sv
// Shared types and constants for the multi-channel UART baud generator.
// Optional mid-bit sample pulse is enabled by defining UART_BAUD_SAMPLE_EN.
package uart_baud_pkg;

   // Widest divisor fields carried on the internal config bus
   localparam int CNT_W_MAX  = 32;
   localparam int FRAC_W_MAX = 8;

   // Legal oversample range (must also be a power of two)
   localparam int OS_MIN = 4;
   localparam int OS_MAX = 32;

   // Divisor record; fields are zero-extended from the instance widths
   typedef struct packed {
      logic [CNT_W_MAX-1:0]  int_div;
      logic [FRAC_W_MAX-1:0] frac_div;
   } baud_cfg_t;

   // Channel-select width; a single channel still needs one select bit
   function automatic int ch_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic bit os_legal(input int n);
      return (n >= OS_MIN) && (n <= OS_MAX) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/uart_baud_chan.sv
// One baud channel: integer down-counter, fractional error accumulator,
// oversample counter and an active/shadow divisor pair with a pending flag.
// Optional mid-bit sample pulse is enabled by defining UART_BAUD_SAMPLE_EN.
module uart_baud_chan
   import uart_baud_pkg::*;
#(
   parameter int CNT_W      = 13,
   parameter int FRAC_W     = 3,
   parameter int OVERSAMPLE = 16
) (
   input  logic      clk,
   input  logic      aresetn,
   input  logic      en_i,
   input  logic      wr_i,
   input  baud_cfg_t cfg_i,
   output logic      pend_o,
   output logic      tick_o,
   output logic      xmit_o,
   output logic      sample_o
);

   localparam int OS_W = $clog2(OVERSAMPLE);
   localparam int FS_W = FRAC_W_MAX + 1;
   localparam int IS_W = CNT_W_MAX + 1;
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [FRAC_W-1:0] acc_q, acc_d;
   logic [OS_W-1:0]   os_q, os_d;
   baud_cfg_t         act_q, act_d;
   baud_cfg_t         sh_q, sh_d;
   logic              pend_q, pend_d;
   logic              tick_q, tick_d;
   logic              xmit_q, xmit_d;
   logic [FS_W-1:0]   frac_sum;
   logic [IS_W-1:0]   int_sum;
   logic              carry;

`ifdef UART_BAUD_SAMPLE_EN
   localparam logic [OS_W-1:0] OS_MID = OS_W'(OVERSAMPLE / 2 - 1);
   logic sample_q, sample_d;
`endif

   // Next-state: reload on cnt==0, count down otherwise, park when disabled
   always_comb begin
      cnt_d  = cnt_q;
      acc_d  = acc_q;
      os_d   = os_q;
      act_d  = act_q;
      sh_d   = sh_q;
      pend_d = pend_q;
      tick_d = 1'b0;
      xmit_d = 1'b0;
`ifdef UART_BAUD_SAMPLE_EN
      sample_d = 1'b0;
`endif
      // Wide sums: any bit above the instance width is the carry / overflow
      frac_sum = {1'b0, act_q.frac_div} + FS_W'(acc_q);
      carry    = |frac_sum[FS_W-1:FRAC_W];
      int_sum  = {1'b0, act_q.int_div} + IS_W'(carry);

      // Pending blocks a second write, so shadow load and pend clear never collide
      if (wr_i && !pend_q) begin
         sh_d   = cfg_i;
         pend_d = 1'b1;
      end

      if (!en_i) begin
         cnt_d = '0;
         acc_d = '0;
         os_d  = '0;
         if (pend_q) begin
            act_d  = sh_q;
            pend_d = 1'b0;
         end
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end else begin
         // Reload uses the old active divisor; a pending shadow lands for the next one
         tick_d = 1'b1;
         os_d   = os_q + 1'b1;
         acc_d  = frac_sum[FRAC_W-1:0];
         cnt_d  = (|int_sum[IS_W-1:CNT_W]) ? '1 : int_sum[CNT_W-1:0];
         xmit_d = (os_q == OS_LAST);
`ifdef UART_BAUD_SAMPLE_EN
         sample_d = (os_q == OS_MID);
`endif
         if (pend_q) begin
            act_d  = sh_q;
            pend_d = 1'b0;
         end
      end
   end

   // State and registered pulses, cleared asynchronously
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         cnt_q  <= '0;
         acc_q  <= '0;
         os_q   <= '0;
         act_q  <= '0;
         sh_q   <= '0;
         pend_q <= 1'b0;
         tick_q <= 1'b0;
         xmit_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
         os_q   <= os_d;
         act_q  <= act_d;
         sh_q   <= sh_d;
         pend_q <= pend_d;
         tick_q <= tick_d;
         xmit_q <= xmit_d;
      end
   end

`ifdef UART_BAUD_SAMPLE_EN
   // Mid-bit receive sample pulse
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) sample_q <= 1'b0;
      else          sample_q <= sample_d;
   end
   assign sample_o = sample_q;
`else
   assign sample_o = 1'b0;
`endif

   assign pend_o = pend_q;
   assign tick_o = tick_q;
   assign xmit_o = xmit_q;

endmodule

// File: rtl/uart_baud_gen_mc.sv
// Multi-channel fractional baud generator: config decode, cfg_ready mux and
// one uart_baud_chan per channel.
// Optional mid-bit sample pulse is enabled by defining UART_BAUD_SAMPLE_EN.
module uart_baud_gen_mc
   import uart_baud_pkg::*;
#(
   parameter  int CHANNELS   = 2,
   parameter  int CNT_W      = 13,
   parameter  int FRAC_W     = 3,
   parameter  int OVERSAMPLE = 16,
   localparam int CH_W       = ch_w(CHANNELS)
) (
   input  logic                clk,
   input  logic                aresetn,
   input  logic [CHANNELS-1:0] chan_en_i,
   input  logic                cfg_valid_i,
   output logic                cfg_ready_o,
   input  logic [CH_W-1:0]     cfg_chan_i,
   input  logic [CNT_W-1:0]    cfg_int_i,
   input  logic [FRAC_W-1:0]   cfg_frac_i,
   output logic [CHANNELS-1:0] baud_tick_o,
   output logic [CHANNELS-1:0] xmit_pulse_o,
   output logic [CHANNELS-1:0] sample_pulse_o
);

   if (!os_legal(OVERSAMPLE) || CHANNELS < 1 || CHANNELS > 16 ||
       FRAC_W < 1 || FRAC_W > FRAC_W_MAX || CNT_W < 1 || CNT_W > CNT_W_MAX) begin : g_bad_param
      $error("uart_baud_gen_mc: illegal parameter set");
   end

   baud_cfg_t           cfg_bus;
   logic [CHANNELS-1:0] pend;
   logic [CHANNELS-1:0] wr_en;

   assign cfg_bus.int_div  = CNT_W_MAX'(cfg_int_i);
   assign cfg_bus.frac_div = FRAC_W_MAX'(cfg_frac_i);

   // Ready follows the addressed channel; unmapped channels accept and drop
   always_comb begin
      cfg_ready_o = 1'b1;
      wr_en       = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (cfg_chan_i == CH_W'(i)) begin
            cfg_ready_o = ~pend[i];
            wr_en[i]    = cfg_valid_i & ~pend[i];
         end
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      uart_baud_chan #(
         .CNT_W      (CNT_W),
         .FRAC_W     (FRAC_W),
         .OVERSAMPLE (OVERSAMPLE)
      ) u_chan (
         .clk      (clk),
         .aresetn  (aresetn),
         .en_i     (chan_en_i[g]),
         .wr_i     (wr_en[g]),
         .cfg_i    (cfg_bus),
         .pend_o   (pend[g]),
         .tick_o   (baud_tick_o[g]),
         .xmit_o   (xmit_pulse_o[g]),
         .sample_o (sample_pulse_o[g])
      );
   end

endmodule

// File: tb/tb_uart_baud_gen_mc.sv
// Directed bench for uart_baud_gen_mc (3 channels, 13.3 divisor, x16).
module tb_uart_baud_gen_mc;

   localparam int CHANNELS = 3;
   localparam int CNT_W    = 13;
   localparam int FRAC_W   = 3;
   localparam int CH_W     = 2;

   logic                clk = 1'b0;
   logic                aresetn;
   logic [CHANNELS-1:0] chan_en;
   logic                cfg_valid;
   logic                cfg_ready;
   logic [CH_W-1:0]     cfg_chan;
   logic [CNT_W-1:0]    cfg_int;
   logic [FRAC_W-1:0]   cfg_frac;
   logic [CHANNELS-1:0] baud_tick;
   logic [CHANNELS-1:0] xmit_pulse;
   logic [CHANNELS-1:0] sample_pulse;

   int total  = 0;
   int passed = 0;
   int tq0[$];
   int tq1[$];
   int xq0[$];
   int sq0[$];
   int xnt;

   always #5 clk = ~clk;

   uart_baud_gen_mc #(
      .CHANNELS   (CHANNELS),
      .CNT_W      (CNT_W),
      .FRAC_W     (FRAC_W),
      .OVERSAMPLE (16)
   ) dut (
      .clk            (clk),
      .aresetn        (aresetn),
      .chan_en_i      (chan_en),
      .cfg_valid_i    (cfg_valid),
      .cfg_ready_o    (cfg_ready),
      .cfg_chan_i     (cfg_chan),
      .cfg_int_i      (cfg_int),
      .cfg_frac_i     (cfg_frac),
      .baud_tick_o    (baud_tick),
      .xmit_pulse_o   (xmit_pulse),
      .sample_pulse_o (sample_pulse)
   );

   // Write a divisor to a disabled channel; the disabled edge promotes it to active
   task automatic program_ch(input int ch, input int iv, input int fv);
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_chan  = CH_W'(ch);
      cfg_int   = CNT_W'(iv);
      cfg_frac  = FRAC_W'(fv);
      @(negedge clk);
      cfg_valid = 1'b0;
      @(negedge clk);
   endtask

   // Record pulse sample indices (1 = first negedge after the call)
   task automatic capture(input int n);
      tq0.delete(); tq1.delete(); xq0.delete(); sq0.delete();
      xnt = 0;
      for (int j = 1; j <= n; j++) begin
         @(negedge clk);
         if (baud_tick[0])   tq0.push_back(j);
         if (baud_tick[1])   tq1.push_back(j);
         if (xmit_pulse[0])  xq0.push_back(j);
         if (sample_pulse[0]) sq0.push_back(j);
         if (xmit_pulse[0] && !baud_tick[0]) xnt++;
      end
   endtask

   task automatic test_reset();
      aresetn = 1'b0; chan_en = '0; cfg_valid = 1'b0;
      cfg_chan = '0; cfg_int = '0; cfg_frac = '0;
      repeat (3) @(negedge clk);
      total++; if (baud_tick !== 3'b000) $display("FAIL reset_tick got=%b want=000", baud_tick); else passed++;
      total++; if (xmit_pulse !== 3'b000) $display("FAIL reset_xmit got=%b want=000", xmit_pulse); else passed++;
      total++; if (sample_pulse !== 3'b000) $display("FAIL reset_sample got=%b want=000", sample_pulse); else passed++;
      total++; if (cfg_ready !== 1'b1) $display("FAIL reset_ready got=%b want=1", cfg_ready); else passed++;
      aresetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_int3();
      int bad = 0;
      int a, b;
      program_ch(0, 3, 0);
      chan_en = 3'b001;
      capture(130);
      for (int k = 0; k + 1 < tq0.size(); k++) if (tq0[k+1] - tq0[k] != 4) bad++;
      a = (xq0.size() > 0) ? xq0[0] : -1;
      b = (xq0.size() > 1) ? xq0[1] : -1;
      total++; if (((tq0.size() > 0) ? tq0[0] : -1) != 1) $display("FAIL int3_first_tick got=%0d want=1", (tq0.size() > 0) ? tq0[0] : -1); else passed++;
      total++; if (tq0.size() != 33) $display("FAIL int3_tick_count got=%0d want=33", tq0.size()); else passed++;
      total++; if (bad != 0) $display("FAIL int3_spacing bad=%0d want=0", bad); else passed++;
      total++; if (xq0.size() != 2) $display("FAIL int3_xmit_count got=%0d want=2", xq0.size()); else passed++;
      total++; if (a != 61) $display("FAIL int3_xmit0 got=%0d want=61", a); else passed++;
      total++; if (b != 125) $display("FAIL int3_xmit1 got=%0d want=125", b); else passed++;
      total++; if (xnt != 0) $display("FAIL int3_xmit_on_tick got=%0d want=0", xnt); else passed++;
      total++; if (tq1.size() != 0) $display("FAIL int3_ch1_idle got=%0d want=0", tq1.size()); else passed++;
      chan_en = '0;
      @(negedge clk);
   endtask

   task automatic test_frac();
      int bad = 0;
      int span, a, b;
      program_ch(0, 3, 4);
      chan_en = 3'b001;
      capture(160);
      for (int k = 0; k + 1 < tq0.size(); k++) if (tq0[k+1] - tq0[k] != ((k % 2 == 0) ? 4 : 5)) bad++;
      span = (tq0.size() > 16) ? tq0[16] - tq0[0] : -1;
      a = (xq0.size() > 0) ? xq0[0] : -1;
      b = (xq0.size() > 1) ? xq0[1] - xq0[0] : -1;
      total++; if (bad != 0) $display("FAIL frac_spacing bad=%0d want=0", bad); else passed++;
      total++; if (span != 72) $display("FAIL frac_16tick_span got=%0d want=72", span); else passed++;
      total++; if (a != 68) $display("FAIL frac_xmit0 got=%0d want=68", a); else passed++;
      total++; if (b != 72) $display("FAIL frac_xmit_period got=%0d want=72", b); else passed++;
      chan_en = '0;
      @(negedge clk);
   endtask

   task automatic test_int0();
      int a, b;
      program_ch(0, 0, 0);
      chan_en = 3'b001;
      capture(40);
      a = (xq0.size() > 0) ? xq0[0] : -1;
      b = (xq0.size() > 1) ? xq0[1] : -1;
      total++; if (tq0.size() != 40) $display("FAIL int0_tick_every_clk got=%0d want=40", tq0.size()); else passed++;
      total++; if (a != 16) $display("FAIL int0_xmit0 got=%0d want=16", a); else passed++;
      total++; if (b != 32) $display("FAIL int0_xmit1 got=%0d want=32", b); else passed++;
      chan_en = '0;
      @(negedge clk);
   endtask

   task automatic test_reprogram();
      int exp0[10] = '{1, 11, 21, 31, 41, 46, 51, 56, 61, 66};
      int bad0 = 0;
      int bad1 = 0;
      program_ch(0, 9, 0);
      program_ch(1, 6, 0);
      cfg_chan = '0;
      chan_en  = 3'b011;
      tq0.delete(); tq1.delete();
      for (int j = 1; j <= 70; j++) begin
         @(negedge clk);
         if (baud_tick[0]) tq0.push_back(j);
         if (baud_tick[1]) tq1.push_back(j);
         if (j == 24) begin
            total++; if (cfg_ready !== 1'b1) $display("FAIL reprog_ready_before got=%b want=1", cfg_ready); else passed++;
            cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_int = 13'd4; cfg_frac = 3'd0;
         end
         if (j == 25) begin
            cfg_valid = 1'b0;
            #1;
            total++; if (cfg_ready !== 1'b0) $display("FAIL reprog_ready_low got=%b want=0", cfg_ready); else passed++;
         end
         if (j == 30) begin
            total++; if (cfg_ready !== 1'b0) $display("FAIL reprog_ready_held got=%b want=0", cfg_ready); else passed++;
         end
         if (j == 31) begin
            total++; if (cfg_ready !== 1'b1) $display("FAIL reprog_ready_on_tick got=%b want=1", cfg_ready); else passed++;
         end
      end
      for (int k = 0; k < 10; k++) if (k >= tq0.size() || tq0[k] != exp0[k]) bad0++;
      for (int k = 0; k + 1 < tq1.size(); k++) if (tq1[k+1] - tq1[k] != 7) bad1++;
      total++; if (tq0.size() != 10) $display("FAIL reprog_ch0_count got=%0d want=10", tq0.size()); else passed++;
      total++; if (bad0 != 0) $display("FAIL reprog_ch0_times bad=%0d want=0", bad0); else passed++;
      total++; if (tq1.size() != 10 || bad1 != 0) $display("FAIL reprog_ch1_cadence count=%0d bad=%0d want=10/0", tq1.size(), bad1); else passed++;
      chan_en = '0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int a;
      program_ch(0, 3, 0);
      chan_en = 3'b001;
      repeat (9) @(negedge clk);
      total++; if (baud_tick[0] !== 1'b1) $display("FAIL rstmid_pre_tick got=%b want=1", baud_tick[0]); else passed++;
      aresetn = 1'b0;
      #1;
      total++; if (baud_tick !== 3'b000 || xmit_pulse !== 3'b000) $display("FAIL rstmid_async_clear tick=%b xmit=%b want=000/000", baud_tick, xmit_pulse); else passed++;
      @(negedge clk);
      aresetn = 1'b1;
      capture(20);
      a = (xq0.size() > 0) ? xq0[0] : -1;
      total++; if (((tq0.size() > 0) ? tq0[0] : -1) != 1) $display("FAIL rstmid_first_tick got=%0d want=1", (tq0.size() > 0) ? tq0[0] : -1); else passed++;
      total++; if (tq0.size() != 20) $display("FAIL rstmid_tick_count got=%0d want=20", tq0.size()); else passed++;
      total++; if (xq0.size() != 1 || a != 16) $display("FAIL rstmid_xmit count=%0d at=%0d want=1/16", xq0.size(), a); else passed++;
      chan_en = '0;
      @(negedge clk);
   endtask

   task automatic test_saturate();
      program_ch(0, 8191, 7);
      chan_en = 3'b001;
      capture(16400);
      total++; if (tq0.size() != 3) $display("FAIL sat_tick_count got=%0d want=3", tq0.size()); else passed++;
      total++; if (((tq0.size() > 1) ? tq0[1] : -1) != 8193) $display("FAIL sat_tick1 got=%0d want=8193", (tq0.size() > 1) ? tq0[1] : -1); else passed++;
      total++; if (((tq0.size() > 2) ? tq0[2] : -1) != 16385) $display("FAIL sat_tick2 got=%0d want=16385", (tq0.size() > 2) ? tq0[2] : -1); else passed++;
      chan_en = '0;
      @(negedge clk);
   endtask

   task automatic test_sample_oor();
      int bad = 0;
      int a;
      program_ch(0, 1, 0);
      chan_en = 3'b001;
      capture(70);
      a = (xq0.size() > 0) ? xq0[0] : -1;
      total++; if (a != 31) $display("FAIL smp_xmit0 got=%0d want=31", a); else passed++;
`ifdef UART_BAUD_SAMPLE_EN
      total++; if (sq0.size() != 2) $display("FAIL smp_count got=%0d want=2", sq0.size()); else passed++;
      total++; if (((sq0.size() > 0) ? sq0[0] : -1) != 15) $display("FAIL smp_first got=%0d want=15", (sq0.size() > 0) ? sq0[0] : -1); else passed++;
      total++; if (((sq0.size() > 0) ? a - sq0[0] : -1) != 16) $display("FAIL smp_to_xmit got=%0d want=16", (sq0.size() > 0) ? a - sq0[0] : -1); else passed++;
`else
      total++; if (sq0.size() != 0) $display("FAIL smp_tied_low got=%0d want=0", sq0.size()); else passed++;
`endif
      cfg_chan = 2'd3; cfg_int = 13'd0; cfg_frac = 3'd0; cfg_valid = 1'b1;
      #1;
      total++; if (cfg_ready !== 1'b1) $display("FAIL oor_ready got=%b want=1", cfg_ready); else passed++;
      @(negedge clk);
      cfg_valid = 1'b0; cfg_chan = 2'd0;
      #1;
      total++; if (cfg_ready !== 1'b1) $display("FAIL oor_ch0_not_pending got=%b want=1", cfg_ready); else passed++;
      capture(20);
      for (int k = 0; k + 1 < tq0.size(); k++) if (tq0[k+1] - tq0[k] != 2) bad++;
      total++; if (tq0.size() != 10 || bad != 0) $display("FAIL oor_ch0_cadence count=%0d bad=%0d want=10/0", tq0.size(), bad); else passed++;
      chan_en = '0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_int3();
      test_frac();
      test_int0();
      test_reprogram();
      test_reset_mid();
      test_saturate();
      test_sample_oor();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
